// File: rtl/cpu_control_logic.sv
// Hazard/control decode for a 3-stage RV32I pipeline: next-PC select, X-stage jump/branch flag,
// and MW->decode forwarding selects, gated by a 2-bit stage-valid tracker.
module cpu_control_logic (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_fd,
  input  logic [31:0] inst_x,
  input  logic [31:0] inst_mw,
  output logic [1:0]  pc_sel,
  output logic        is_j_or_b,
  output logic        wb2d_a,
  output logic        wb2d_b
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_ALU   = 2'd1;
  localparam logic [1:0] PC_RESET = 2'd2;

  logic vld_x_q, vld_x_d;
  logic vld_mw_q, vld_mw_d;

  function automatic logic writes_rd(input logic [31:0] i);
    logic cls;
    case (i[6:0])
      OP_R, OP_IALU, OP_LOAD, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_SYSTEM: cls = 1'b1;
      default: cls = 1'b0;
    endcase
    return cls && (i[11:7] != 5'd0);
  endfunction

  // CSR immediate forms (funct3[2]=1) carry a uimm in the rs1 field, not a register.
  function automatic logic uses_rs1(input logic [31:0] i);
    logic u;
    case (i[6:0])
      OP_R, OP_IALU, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR: u = 1'b1;
      OP_SYSTEM: u = ~i[14];
      default: u = 1'b0;
    endcase
    return u;
  endfunction

  function automatic logic uses_rs2(input logic [31:0] i);
    logic u;
    case (i[6:0])
      OP_R, OP_STORE, OP_BRANCH: u = 1'b1;
      default: u = 1'b0;
    endcase
    return u;
  endfunction

  always_comb begin
    vld_x_d  = ~rst;
    vld_mw_d = rst ? 1'b0 : vld_x_q;
  end

  always_ff @(posedge clk) begin
    vld_x_q  <= vld_x_d;
    vld_mw_q <= vld_mw_d;
  end

  logic mw_wr;
  logic x_jump;

  always_comb begin
    mw_wr     = vld_mw_q && writes_rd(inst_mw);
    wb2d_a    = mw_wr && uses_rs1(inst_fd) && (inst_mw[11:7] == inst_fd[19:15]);
    wb2d_b    = mw_wr && uses_rs2(inst_fd) && (inst_mw[11:7] == inst_fd[24:20]);
    x_jump    = vld_x_q && ((inst_x[6:0] == OP_JAL) || (inst_x[6:0] == OP_JALR));
    is_j_or_b = x_jump || (vld_x_q && (inst_x[6:0] == OP_BRANCH));
    // Conditional branches are resolved in the datapath, so only unconditional jumps steer the PC here.
    if (rst)         pc_sel = PC_RESET;
    else if (x_jump) pc_sel = PC_ALU;
    else             pc_sel = PC_PLUS4;
  end

endmodule

// File: tb/tb_cpu_control_logic.sv
// Bench for cpu_control_logic: reset/refill sequences plus a table of decode vectors,
// with expectations queued on drive and popped when outputs are sampled.
module tb_cpu_control_logic;

  typedef struct packed {
    logic [1:0] pc;
    logic       jb;
    logic       a;
    logic       b;
  } exp_t;

  typedef struct {
    string       name;
    logic [31:0] fd;
    logic [31:0] x;
    logic [31:0] mw;
    exp_t        e;
  } vec_t;

  localparam logic [31:0] ADDI_X5   = 32'h00100293;
  localparam logic [31:0] ADD_655   = 32'h00528333;
  localparam logic [31:0] JAL_X1    = 32'h008000EF;
  localparam logic [31:0] NOP       = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_fd, inst_x, inst_mw;
  logic [1:0]  pc_sel;
  logic        is_j_or_b, wb2d_a, wb2d_b;

  int   total = 0;
  int   bad   = 0;
  exp_t sb_q[$];
  vec_t vecs[$];

  cpu_control_logic dut (
    .clk       (clk),
    .rst       (rst),
    .inst_fd   (inst_fd),
    .inst_x    (inst_x),
    .inst_mw   (inst_mw),
    .pc_sel    (pc_sel),
    .is_j_or_b (is_j_or_b),
    .wb2d_a    (wb2d_a),
    .wb2d_b    (wb2d_b)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [1:0] pc, input logic jb, input logic a, input logic b);
    exp_t e;
    e.pc = pc; e.jb = jb; e.a = a; e.b = b;
    return e;
  endfunction

  task automatic drive(input logic r, input logic [31:0] fd, input logic [31:0] x, input logic [31:0] mw);
    rst = r; inst_fd = fd; inst_x = x; inst_mw = mw;
  endtask

  task automatic check(input string nm);
    exp_t e, got;
    total++;
    got = {pc_sel, is_j_or_b, wb2d_a, wb2d_b};
    if (sb_q.size() == 0) begin
      bad++;
      $display("FAIL %s: no expectation queued, got pc_sel=%0d jb=%b a=%b b=%b", nm, got.pc, got.jb, got.a, got.b);
    end else begin
      e = sb_q.pop_front();
      if (got !== e) begin
        bad++;
        $display("FAIL %s: got pc_sel=%0d jb=%b a=%b b=%b, want pc_sel=%0d jb=%b a=%b b=%b",
                 nm, got.pc, got.jb, got.a, got.b, e.pc, e.jb, e.a, e.b);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input string nm, input logic [31:0] fd, input logic [31:0] x,
                         input logic [31:0] mw, input exp_t e);
    vec_t v;
    v.name = nm; v.fd = fd; v.x = x; v.mw = mw; v.e = e;
    vecs.push_back(v);
  endtask

  initial begin
    add_vec("fwd_both",     ADD_655,      ADD_655,      ADDI_X5,      mk(2'd0, 1'b0, 1'b1, 1'b1));
    add_vec("rd_x0",        32'h00000333, ADD_655,      NOP,          mk(2'd0, 1'b0, 1'b0, 1'b0));
    add_vec("mw_store",     ADD_655,      NOP,          32'h00532023, mk(2'd0, 1'b0, 1'b0, 1'b0));
    add_vec("fd_lui",       32'h000282B7, NOP,          ADDI_X5,      mk(2'd0, 1'b0, 1'b0, 1'b0));
    add_vec("x_jal",        NOP,          JAL_X1,       NOP,          mk(2'd1, 1'b1, 1'b0, 1'b0));
    add_vec("x_beq",        NOP,          32'h00628463, NOP,          mk(2'd0, 1'b1, 1'b0, 1'b0));
    add_vec("x_jalr",       NOP,          32'h000080E7, NOP,          mk(2'd1, 1'b1, 1'b0, 1'b0));
    add_vec("x_add",        NOP,          ADD_655,      NOP,          mk(2'd0, 1'b0, 1'b0, 1'b0));
    add_vec("fd_addi_rs1",  32'h00128393, NOP,          ADDI_X5,      mk(2'd0, 1'b0, 1'b1, 1'b0));
    add_vec("fd_sw_rs2",    32'h00532023, NOP,          ADDI_X5,      mk(2'd0, 1'b0, 1'b0, 1'b1));
    add_vec("fd_csr_imm",   32'h3002D073, NOP,          ADDI_X5,      mk(2'd0, 1'b0, 1'b0, 1'b0));
    add_vec("fd_csr_reg",   32'h30029073, NOP,          ADDI_X5,      mk(2'd0, 1'b0, 1'b1, 1'b0));
    add_vec("mw_unknown",   ADD_655,      32'h000002FF, 32'h000002FF, mk(2'd0, 1'b0, 1'b0, 1'b0));
    add_vec("mw_jal_x5",    ADD_655,      NOP,          32'h008002EF, mk(2'd0, 1'b0, 1'b1, 1'b1));
    add_vec("mw_csr_x5",    ADD_655,      NOP,          32'h300022F3, mk(2'd0, 1'b0, 1'b1, 1'b1));
    add_vec("fd_rs2_only",  32'h00500333, NOP,          ADDI_X5,      mk(2'd0, 1'b0, 1'b0, 1'b1));

    // Reset with a jump in X and a forwarding pair present, so masking is observable.
    drive(1'b1, ADD_655, JAL_X1, ADDI_X5);
    step(); sb_q.push_back(mk(2'd2, 1'b0, 1'b0, 1'b0)); check("rst_edge1");
    step(); sb_q.push_back(mk(2'd2, 1'b0, 1'b0, 1'b0)); check("rst_edge2");
    drive(1'b0, ADD_655, JAL_X1, ADDI_X5);
    #1;     sb_q.push_back(mk(2'd0, 1'b0, 1'b0, 1'b0)); check("rst_release");
    step(); sb_q.push_back(mk(2'd1, 1'b1, 1'b0, 1'b0)); check("refill_x");
    step(); sb_q.push_back(mk(2'd1, 1'b1, 1'b1, 1'b1)); check("refill_mw");

    foreach (vecs[i]) begin
      drive(1'b0, vecs[i].fd, vecs[i].x, vecs[i].mw);
      sb_q.push_back(vecs[i].e);
      #2;
      check(vecs[i].name);
      step();
    end

    // Mid-run reset: pc_sel reacts at once, valid-gated outputs drop after the edge.
    drive(1'b0, ADD_655, JAL_X1, ADDI_X5);
    #1;     sb_q.push_back(mk(2'd1, 1'b1, 1'b1, 1'b1)); check("mid_pre");
    drive(1'b1, ADD_655, JAL_X1, ADDI_X5);
    #1;     sb_q.push_back(mk(2'd2, 1'b1, 1'b1, 1'b1)); check("mid_rst_same");
    step(); sb_q.push_back(mk(2'd2, 1'b0, 1'b0, 1'b0)); check("mid_rst_edge");
    drive(1'b0, ADD_655, JAL_X1, ADDI_X5);
    #1;     sb_q.push_back(mk(2'd0, 1'b0, 1'b0, 1'b0)); check("mid_release");
    step(); sb_q.push_back(mk(2'd1, 1'b1, 1'b0, 1'b0)); check("mid_refill_x");
    step(); sb_q.push_back(mk(2'd1, 1'b1, 1'b1, 1'b1)); check("mid_refill_mw");

    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: %0d expectations left, want 0", sb_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
